// File: rtl/mux_rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux_arb_pkg;
    localparam int NUM_REQ      = 8;
    localparam int SEL_W        = 3;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_HOLD_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/mux_rr_arbiter_8_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping mod NUM_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);
    // Scan farthest-to-nearest so the candidate closest to ptr is written last and wins.
    always_comb begin : pick
        logic [SEL_W-1:0] w_cand;
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = ptr + SEL_W'(i);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter_8.sv
// Round-robin arbiter driving a shared 8:1 mux with bounded hold per grant.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (in0 highest).
module mux_rr_arbiter_8
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   in3,
    input  logic [WIDTH-1:0]   in4,
    input  logic [WIDTH-1:0]   in5,
    input  logic [WIDTH-1:0]   in6,
    input  logic [WIDTH-1:0]   in7,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               busy
);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    logic [NUM_REQ-1:0][WIDTH-1:0] w_in;
    logic [SEL_W-1:0]              w_ptr;
    logic [SEL_W-1:0]              w_idx;
    logic                          w_any;
    logic                          w_grant;
    logic                          w_capture;
    logic                          w_release;
    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [NUM_REQ-1:0]            r_gnt;
    logic [SEL_W-1:0]              r_sel;
    logic [WIDTH-1:0]              r_out;
    logic                          r_out_valid;
    logic [3:0]                    r_hold;

    assign w_in = {in7, in6, in5, in4, in3, in2, in1, in0};

`ifdef ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_ptr <= '0;
        else if (w_release) r_ptr <= r_sel + SEL_W'(1);
    end

    assign w_ptr = r_ptr;
`endif

    rr_pick u_pick (
        .req (req),
        .ptr (w_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Requester drop releases without capture; hold expiry captures the final word on the way out.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    w_release = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    if (r_hold == HOLD_LAST) w_release = 1'b1;
                end
                if (w_release) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt       <= '0;
            r_sel       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_out_valid <= w_capture;
            if (w_grant) begin
                r_gnt  <= NUM_REQ'(1) << w_idx;
                r_sel  <= w_idx;
                r_hold <= '0;
            end
            if (w_capture) begin
                r_out  <= w_in[r_sel];
                r_hold <= r_hold + 4'd1;
            end
            if (w_release) r_gnt <= '0;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == GRANT);
endmodule

// File: tb/tb_mux_rr_arbiter_8.sv
// Directed scoreboard bench for mux_rr_arbiter_8 (HOLD_MAX=4, WIDTH=8).
module tb_mux_rr_arbiter_8;
    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] in_d [8];
    logic [7:0] gnt;
    logic [2:0] sel;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    mux_rr_arbiter_8 #(.WIDTH(8), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in_d[0]),
        .in1       (in_d[1]),
        .in2       (in_d[2]),
        .in3       (in_d[3]),
        .in4       (in_d[4]),
        .in5       (in_d[5]),
        .in6       (in_d[6]),
        .in7       (in_d[7]),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every valid output word must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", {21'd0, sel, out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_word", {21'd0, sel, out}, {21'd0, e.sel, e.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int idx, input int n);
        exp_t e;
        e.sel  = 3'(idx);
        e.data = 8'(128 >> idx);
        repeat (n) q.push_back(e);
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [7:0] one;
        one = 8'd1;
        step();
        chk({tag, "_gnt"}, gnt, one << idx);
        chk({tag, "_sel"}, sel, idx);
        chk({tag, "_busy"}, busy, 1);
    endtask

    // Full-length grant: one grant edge then HOLD_MAX captures, ending released.
    task automatic full_grant(input string tag, input int idx);
        push(idx, 4);
        expect_grant(tag, idx);
        repeat (4) step();
        chk({tag, "_rel_gnt"}, gnt, 0);
        chk({tag, "_rel_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        for (int k = 0; k < 8; k++) in_d[k] = 8'(128 >> k);
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // All requesting: grants sweep 0..7 then wrap to 0.
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            full_grant("sweep", 0);
`else
            full_grant("sweep", k % 8);
`endif
        end
        req = 8'h00;
        step();
        chk("sweep_idle_busy", busy, 0);
        chk("sweep_idle_gnt", gnt, 0);

        // Single requester held: regrant after one bubble, then drop on the grant cycle.
        req = 8'h01;
        full_grant("single", 0);
        chk("single_last_valid", out_valid, 1);
        chk("single_last_out", out, 128);
        expect_grant("regrant", 0);
        chk("regrant_valid", out_valid, 0);
        req = 8'h00;
        step();
        chk("drop0_gnt", gnt, 0);
        chk("drop0_valid", out_valid, 0);

        // Requester 3 drops after two words.
        req = 8'h08;
        push(3, 2);
        expect_grant("drop3", 3);
        step();
        step();
        req = 8'h00;
        step();
        chk("drop3_gnt", gnt, 0);
        chk("drop3_valid", out_valid, 0);
        chk("drop3_out_hold", out, 16);
        chk("drop3_q", q.size(), 0);

`ifndef ARB_FIXED_PRIO_EN
        // Pointer at 4: idx 4 beats idx 1, then idx 1; pointer at 2: idx 7 beats idx 1.
        req = 8'h12;
        full_grant("p4", 4);
        full_grant("p5", 1);
        req = 8'h82;
        full_grant("p2", 7);
        full_grant("p0", 1);
        req = 8'h00;
        step();
        chk("rr_idle_gnt", gnt, 0);
`endif

        // Mid-grant reset; non-granted input change must not leak through.
        req = 8'h04;
        push(2, 2);
        expect_grant("abort", 2);
        step();
        in_d[5] = 8'hAA;
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_out", out, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sel", sel, 0);
        in_d[5] = 8'd4;
        req = 8'h05;
        @(negedge clk);
        reset = 1'b0;
        // Pointer reset to 0 makes idx 0 win over idx 2.
        full_grant("post_rst", 0);
`ifdef ARB_FIXED_PRIO_EN
        full_grant("post_rst2", 0);
`else
        full_grant("post_rst2", 2);
`endif
        req = 8'h00;
        step();
        step();
        chk("end_busy", busy, 0);
        chk("end_q", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
